he_poly_dma: RTL

- Parametrised memory-side DMA for the HE accelerator.
- Per job:
  - streams NUM_RD_POLYS polynomials of DEGREE_N coefficients from memory into the accelerator;
  - pulses accel start and waits for accel done;
  - drains NUM_WR_POLYS result polynomials back to memory.
- Sits between the accelerator core and the single-outstanding-request memory port.
- Generalises the fixed-count wrapper: programmable base addresses, parametrised width/poly counts, valid/ready streams on the accelerator side.

---
 rtl/he_poly_dma.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/he_poly_dma.sv
// he_poly_dma: memory-side DMA feeding the HE accelerator.
// Optional cycle/stall counters: define HE_DMA_PERF_CNT_EN.
module he_poly_dma #(
    parameter int BIT_WIDTH = 64,
    parameter int ADDR_W = 32,
    parameter int DEGREE_N = 4096,
    parameter int NUM_RD_POLYS = 4,
    parameter int NUM_WR_POLYS = 2 * 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    rd_base_i,
    input  logic [ADDR_W-1:0]    wr_base_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 mem_read_o,
    output logic [ADDR_W-1:0]    addr_read_o,
    input  logic                 mem_resp_read_i,
    input  logic [BIT_WIDTH-1:0] data_i,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    addr_write_o,
    output logic [BIT_WIDTH-1:0] data_o,
    input  logic                 mem_resp_write_i,
    output logic                 ld_valid_o,
    output logic [BIT_WIDTH-1:0] ld_data_o,
    input  logic                 ld_ready_i,
    output logic                 accel_start_o,
    input  logic                 accel_done_i,
    input  logic                 st_valid_i,
    input  logic [BIT_WIDTH-1:0] st_data_i,
`ifdef HE_DMA_PERF_CNT_EN
    output logic [31:0]          perf_cycles_o,
    output logic [31:0]          perf_stall_o,
`endif
    output logic                 st_ready_o
);

    localparam int RD_WORDS = NUM_RD_POLYS * DEGREE_N;
    localparam int WR_WORDS = NUM_WR_POLYS * DEGREE_N;
    localparam int MAX_WORDS =
        (RD_WORDS > WR_WORDS) ? RD_WORDS : WR_WORDS;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int BYTES = BIT_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_LD_PUSH,
        S_ACCEL,
        S_ST_PULL,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [BIT_WIDTH-1:0] r_ld_data;
    logic [BIT_WIDTH-1:0] r_wr_data;
    logic                 r_accel_first;
    logic                 w_rd_last;
    logic                 w_wr_last;

    assign w_rd_last = (r_cnt == CNT_W'(RD_WORDS - 1));
    assign w_wr_last = (r_cnt == CNT_W'(WR_WORDS - 1));

    assign addr_read_o  = r_rd_addr;
    assign addr_write_o = r_wr_addr;
    assign ld_data_o    = r_ld_data;
    assign data_o       = r_wr_data;

    // Next-state selection and per-state handshake outputs.
    always_comb begin
        w_next        = r_state;
        ready_o       = 1'b0;
        mem_read_o    = 1'b0;
        ld_valid_o    = 1'b0;
        accel_start_o = 1'b0;
        st_ready_o    = 1'b0;
        mem_write_o   = 1'b0;
        done_o        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) w_next = S_RD_REQ;
            end
            S_RD_REQ: begin
                mem_read_o = 1'b1;
                if (mem_resp_read_i) w_next = S_LD_PUSH;
            end
            S_LD_PUSH: begin
                ld_valid_o = 1'b1;
                if (ld_ready_i)
                    w_next = w_rd_last ? S_ACCEL : S_RD_REQ;
            end
            S_ACCEL: begin
                accel_start_o = r_accel_first;
                if (accel_done_i) w_next = S_ST_PULL;
            end
            S_ST_PULL: begin
                st_ready_o = 1'b1;
                if (st_valid_i) w_next = S_WR_REQ;
            end
            S_WR_REQ: begin
                mem_write_o = 1'b1;
                if (mem_resp_write_i)
                    w_next = w_wr_last ? S_DONE : S_ST_PULL;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus address, counter and data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_ld_data     <= '0;
            r_wr_data     <= '0;
            r_accel_first <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_accel_first <= (w_next == S_ACCEL) &&
                             (r_state != S_ACCEL);
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_rd_addr <= rd_base_i;
                        r_wr_addr <= wr_base_i;
                        r_cnt     <= '0;
                    end
                end
                S_RD_REQ: begin
                    if (mem_resp_read_i) r_ld_data <= data_i;
                end
                S_LD_PUSH: begin
                    if (ld_ready_i) begin
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_rd_addr <= r_rd_addr + ADDR_W'(BYTES);
                    end
                end
                S_ACCEL: begin
                    if (accel_done_i) r_cnt <= '0;
                end
                S_ST_PULL: begin
                    if (st_valid_i) r_wr_data <= st_data_i;
                end
                S_WR_REQ: begin
                    if (mem_resp_write_i) begin
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_wr_addr <= r_wr_addr + ADDR_W'(BYTES);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HE_DMA_PERF_CNT_EN
    logic w_stall;
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stall;

    assign w_stall = (mem_read_o && !mem_resp_read_i) ||
                     (mem_write_o && !mem_resp_write_i);
    assign perf_cycles_o = r_perf_cycles;
    assign perf_stall_o  = r_perf_stall;

    // Saturating busy and memory-stall counters, cleared per job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (r_state == S_IDLE) begin
            if (start_i) begin
                r_perf_cycles <= '0;
                r_perf_stall  <= '0;
            end
        end else begin
            if (r_perf_cycles != '1)
                r_perf_cycles <= r_perf_cycles + 32'd1;
            if (w_stall && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
`else
    // Default build carries no profiling state.
`endif

endmodule
